// File: rtl/rc5_enc_arbiter.sv
// rc5_enc_arbiter: two-port round-robin arbiter and sequencer in front of the
// single RC5 Encryption core. It grants one requester, launches its block into
// the core with a one-cycle din_valid pulse, waits for the rising edge of
// dout_ready and returns the ciphertext to the owning requester.
//
// Ports:
//   clk, clr (async active-low reset)
//   req{0,1}_din/valid/ack   : plaintext request handshake (ack is combinational)
//   rsp{0,1}_dout/err/valid/ready : ciphertext response handshake
//   core_din/core_din_valid  : launch into the core
//   core_dout/core_dout_ready: result from the core
//   busy                     : high whenever the sequencer is not idle
//
// Optional feature: define RC5_ARB_TIMEOUT_EN to abort an operation after
// TIMEOUT_CYCLES WAIT cycles with rsp_err=1 and rsp_dout=0.
module rc5_enc_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [63:0] req0_din,
    input  logic        req0_valid,
    output logic        req0_ack,
    input  logic [63:0] req1_din,
    input  logic        req1_valid,
    output logic        req1_ack,
    output logic [63:0] rsp0_dout,
    output logic        rsp0_err,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp1_dout,
    output logic        rsp1_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] core_din,
    output logic        core_din_valid,
    input  logic [63:0] core_dout,
    input  logic        core_dout_ready,
    output logic        busy
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                owner;
    logic                last_grant;
    logic                prev_ready;
    logic                rise;
    logic                rsp_hs;
    logic                timeout_hit;
    logic                capture;
    logic [DATA_W-1:0]   cap_data;

    // Completion is a fresh 0->1 transition; a level left high is ignored.
    assign rise     = core_dout_ready && !prev_ready;
    assign capture  = (state == S_WAIT) && (rise || timeout_hit);
    // A completion edge beats a simultaneous timeout.
    assign cap_data = rise ? core_dout : '0;

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (req0_ack || req1_ack) state_next = S_LAUNCH;
            S_LAUNCH:  state_next = S_WAIT;
            S_WAIT:    if (rise || timeout_hit) state_next = S_DELIVER;
            S_DELIVER: if (rsp_hs) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Output decode: round-robin grant in IDLE, response handshake in DELIVER.
    // Grants are gated by clr so acks read 0 while reset is held.
    always_comb begin
        req0_ack = 1'b0;
        req1_ack = 1'b0;
        rsp_hs   = 1'b0;
        if (state == S_IDLE && clr) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                req0_ack = 1'b1;
            end else if (req1_valid) begin
                req1_ack = 1'b1;
            end
        end
        if (state == S_DELIVER) begin
            rsp_hs = owner ? rsp1_ready : rsp0_ready;
        end
    end

    // Registered datapath and outputs, loaded from the next state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            prev_ready     <= 1'b0;
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            core_din       <= '0;
            core_din_valid <= 1'b0;
            busy           <= 1'b0;
            rsp0_valid     <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp0_dout      <= '0;
            rsp1_dout      <= '0;
        end else begin
            prev_ready     <= core_dout_ready;
            core_din_valid <= (state_next == S_LAUNCH);
            busy           <= (state_next != S_IDLE);
            rsp0_valid     <= (state_next == S_DELIVER) && !owner;
            rsp1_valid     <= (state_next == S_DELIVER) && owner;
            if (req0_ack || req1_ack) begin
                core_din   <= req1_ack ? req1_din : req0_din;
                owner      <= req1_ack;
                last_grant <= req1_ack;
            end
            if (capture) begin
                if (owner) begin
                    rsp1_dout <= cap_data;
                end else begin
                    rsp0_dout <= cap_data;
                end
            end
        end
    end

`ifdef RC5_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt;
    logic             err_q;
    logic             err_next;

    assign timeout_hit = (state == S_WAIT) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_next    = (state == S_WAIT) ? (timeout_hit && !rise) : err_q;

    // WAIT-cycle counter and error flag for the owner's response
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            to_cnt   <= '0;
            err_q    <= 1'b0;
            rsp0_err <= 1'b0;
            rsp1_err <= 1'b0;
        end else begin
            to_cnt   <= (state == S_WAIT) ? to_cnt + CNT_W'(1) : '0;
            err_q    <= err_next;
            rsp0_err <= (state_next == S_DELIVER) && !owner && err_next;
            rsp1_err <= (state_next == S_DELIVER) && owner && err_next;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^(32'(TIMEOUT_CYCLES));
    assign timeout_hit = 1'b0;
    assign rsp0_err    = 1'b0;
    assign rsp1_err    = 1'b0;
`endif

endmodule
